pulse_capture: RTL

- Measures an incoming pulse train against the shared PWM tick counter. This is the receive-side counterpart of the counter-compare pulse generator.
- Captures the counter value at each rising and falling edge of the input, and reports the high time and low time in ticks.
- Flags pulses whose high or low phase lasts a full counter period or longer.
- Used for loopback checking of generated PWM and for measuring external PWM inputs.

---
 rtl/pulse_capture.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pulse_capture.sv
// Pulse-train timing capture against a shared tick counter: edge timestamps, high/low durations, overrun flag.
// Optional macro PULSE_CAPTURE_SYNC_EN selects a two-flop input synchronizer instead of a single register.
module pulse_capture #(
  parameter int bitwidth = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [bitwidth-1:0] counter,
  input  logic                signal_in,
  output logic [bitwidth-1:0] tick_number_rising_edge,
  output logic [bitwidth-1:0] tick_number_falling_edge,
  output logic [bitwidth-1:0] high_ticks,
  output logic [bitwidth-1:0] low_ticks,
  output logic                high_valid,
  output logic                low_valid,
  output logic                overrun,
  output logic [1:0]          fsm_state
);

  // Strobes (high_valid, low_valid, overrun) are single-cycle pulses with no back-pressure:
  // the associated data outputs are stable from the strobe cycle until the next capture.
  typedef enum logic [1:0] {
    ARM  = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t state, state_next;
  logic   s, s_prev, primed;
  logic   rise, fall;
  logic   have_rise, have_fall;
  logic   capture_rise, capture_fall, low_update, wrap;

  // primed marks that s holds a real sample rather than its reset value, so ARM
  // cannot mistake a pulse already high at reset release for a fresh low level.
`ifdef PULSE_CAPTURE_SYNC_EN
  logic meta, meta_fill;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta      <= 1'b0;
      s         <= 1'b0;
      meta_fill <= 1'b0;
      primed    <= 1'b0;
    end else begin
      meta      <= signal_in;
      s         <= meta;
      meta_fill <= 1'b1;
      primed    <= meta_fill;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      s      <= 1'b0;
      primed <= 1'b0;
    end else begin
      s      <= signal_in;
      primed <= 1'b1;
    end
  end
`endif

  assign rise      = s & ~s_prev;
  assign fall      = ~s & s_prev;
  assign fsm_state = state;

  always_comb begin
    state_next   = state;
    capture_rise = 1'b0;
    capture_fall = 1'b0;
    low_update   = 1'b0;
    wrap         = 1'b0;
    case (state)
      ARM: begin
        if (primed && !s) state_next = LOW;
      end
      LOW: begin
        if (rise) begin
          capture_rise = 1'b1;
          low_update   = have_fall;
          state_next   = HIGH;
        end else if (have_fall && counter == tick_number_falling_edge) begin
          wrap = 1'b1;
        end
      end
      HIGH: begin
        // A full-period high phase takes priority over a coincident fall.
        if (have_rise && counter == tick_number_rising_edge) begin
          wrap       = 1'b1;
          state_next = ARM;
        end else if (fall) begin
          capture_fall = 1'b1;
          state_next   = LOW;
        end
      end
      default: state_next = ARM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                    <= ARM;
      s_prev                   <= 1'b0;
      have_rise                <= 1'b0;
      have_fall                <= 1'b0;
      tick_number_rising_edge  <= '0;
      tick_number_falling_edge <= '0;
      high_ticks               <= '0;
      low_ticks                <= '0;
      high_valid               <= 1'b0;
      low_valid                <= 1'b0;
      overrun                  <= 1'b0;
    end else begin
      state      <= state_next;
      s_prev     <= s;
      high_valid <= capture_fall;
      low_valid  <= low_update;
      overrun    <= wrap;
      if (capture_rise) begin
        tick_number_rising_edge <= counter;
        have_rise               <= 1'b1;
        if (low_update) low_ticks <= counter - tick_number_falling_edge;
      end
      if (capture_fall) begin
        tick_number_falling_edge <= counter;
        high_ticks               <= counter - tick_number_rising_edge;
        have_fall                <= 1'b1;
      end
      if (wrap) have_fall <= 1'b0;
    end
  end

endmodule
